// File: rtl/bp_be_late_wb_buffer_if.sv
// Producer/scheduler bundle for the late writeback buffer.
// The slave modport is the buffer's view; master is the producer and scheduler side.
interface bp_be_late_wb_buffer_if #(parameter int pkt_width_p = 80);
  logic                   wb_v_i;
  logic                   wb_ready_and_o;
  logic [pkt_width_p-1:0] wb_pkt_i;
  logic                   wb_irf_i;
  logic                   wb_frf_i;
  logic [4:0]             wb_rd_addr_i;
  logic [pkt_width_p-1:0] late_wb_pkt_o;
  logic                   late_wb_v_o;
  logic                   late_wb_force_o;
  logic                   late_wb_yumi_i;
  logic [31:0]            pending_irf_o;
  logic [31:0]            pending_frf_o;

  modport slave (
    input  wb_v_i, wb_pkt_i, wb_irf_i, wb_frf_i, wb_rd_addr_i, late_wb_yumi_i,
    output wb_ready_and_o, late_wb_pkt_o, late_wb_v_o, late_wb_force_o,
           pending_irf_o, pending_frf_o
  );

  modport master (
    output wb_v_i, wb_pkt_i, wb_irf_i, wb_frf_i, wb_rd_addr_i, late_wb_yumi_i,
    input  wb_ready_and_o, late_wb_pkt_o, late_wb_v_o, late_wb_force_o,
           pending_irf_o, pending_frf_o
  );
endinterface

// File: rtl/bp_be_late_wb_buffer.sv
// Circular FIFO holding long-latency results until the scheduler grants a regfile
// write port; tracks pending destinations and raises force when the head starves.
module bp_be_late_wb_buffer #(
  parameter int els_p       = 4,
  parameter int pkt_width_p = 80,
  parameter int starve_p    = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bp_be_late_wb_buffer_if.slave   bus
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = ptr_w + 1;
  localparam int age_w = $clog2(starve_p + 1);

  logic [pkt_width_p-1:0] pkt_mem [els_p];
  logic [4:0]             rd_mem  [els_p];
  logic [els_p-1:0]       irf_mem;
  logic [els_p-1:0]       frf_mem;

  logic [ptr_w-1:0] head_r, tail_r;
  logic [cnt_w-1:0] count_r;
  logic [age_w-1:0] age_r;
  logic [els_p-1:0] valid_r;

  logic enq, deq, empty, full;
  logic [31:0] pend_irf, pend_frf;

  assign empty = (count_r == '0);
  assign full  = (count_r == cnt_w'(els_p));
  assign enq   = bus.wb_v_i & ~full;
  assign deq   = bus.late_wb_yumi_i & ~empty;

  assign bus.wb_ready_and_o  = ~full;
  assign bus.late_wb_v_o     = ~empty;
  assign bus.late_wb_pkt_o   = pkt_mem[head_r];
  assign bus.late_wb_force_o = ~empty & ((age_r >= age_w'(starve_p)) | full);
  assign bus.pending_irf_o   = pend_irf;
  assign bus.pending_frf_o   = pend_frf;

  // Entry payload: written at the tail, never reset
  always_ff @(posedge clk_i) begin
    if (enq) begin
      pkt_mem[tail_r] <= bus.wb_pkt_i;
      rd_mem[tail_r]  <= bus.wb_rd_addr_i;
      irf_mem[tail_r] <= bus.wb_irf_i;
      frf_mem[tail_r] <= bus.wb_frf_i;
    end
  end

  // Control state: pointers, occupancy, head age
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      age_r   <= '0;
      valid_r <= '0;
    end else begin
      if (enq) begin
        tail_r          <= tail_r + ptr_w'(1);
        valid_r[tail_r] <= 1'b1;
      end
      if (deq) begin
        head_r          <= head_r + ptr_w'(1);
        valid_r[head_r] <= 1'b0;
      end
      case ({enq, deq})
        2'b10:   count_r <= count_r + cnt_w'(1);
        2'b01:   count_r <= count_r - cnt_w'(1);
        default: count_r <= count_r;
      endcase
      // A fresh head starts aging from zero; a waiting head saturates at starve_p
      if (deq || (enq && empty))
        age_r <= '0;
      else if (!empty && !bus.late_wb_yumi_i && (age_r < age_w'(starve_p)))
        age_r <= age_r + age_w'(1);
    end
  end

  always_comb begin
    pend_irf = '0;
    pend_frf = '0;
    for (int i = 0; i < els_p; i++) begin
      if (valid_r[i] && irf_mem[i]) pend_irf[rd_mem[i]] = 1'b1;
      if (valid_r[i] && frf_mem[i]) pend_frf[rd_mem[i]] = 1'b1;
    end
    // x0 is hardwired zero, so a write to it is never a hazard
    pend_irf[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i)
      assert (!(bus.late_wb_yumi_i && empty))
        else $error("late_wb_yumi_i asserted while buffer empty");
  end

endmodule

// File: doc/bp_be_late_wb_buffer.md
BP_BE_LATE_WB_BUFFER -- requirements
Module: bp_be_late_wb_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk_i and reset_n_i.
REQ-002 The block SHALL take these parameters (name, default, meaning):
- els_p, 4, buffer depth (power of two, >=2).
- pkt_width_p, 80, opaque late writeback packet width.
- starve_p, 8, head age in cycles at which force is raised.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, clock.
- reset_n_i, in, 1, async active-low reset.
- wb_v_i, in, 1, producer (long-latency unit) result valid.
- wb_ready_and_o, out, 1, buffer can accept this cycle.
- wb_pkt_i, in, pkt_width_p, result packet.
- wb_irf_i, in, 1, result targets the integer regfile.
- wb_frf_i, in, 1, result targets the FP regfile.
- wb_rd_addr_i, in, 5, destination register.
- late_wb_pkt_o, out, pkt_width_p, head packet to the scheduler.
- late_wb_v_o, out, 1, head valid.
- late_wb_force_o, out, 1, scheduler must take the head this cycle.
- late_wb_yumi_i, in, 1, scheduler consumed the head.
- pending_irf_o, out, 32, int destinations with an outstanding late writeback.
- pending_frf_o, out, 32, FP destinations with an outstanding late writeback.

Function
REQ-004 The buffer SHALL be a circular FIFO of els_p entries; each entry holds pkt, irf, frf and rd_addr.
REQ-005 The block SHALL accept an enqueue when wb_v_i & wb_ready_and_o, writing the entry at the tail on the rising edge.
REQ-006 wb_ready_and_o SHALL be count < els_p, and SHALL NOT depend on late_wb_yumi_i (no same-cycle pass-through at full).
REQ-007 There SHALL be no bypass: an entry enqueued in cycle N is first visible on late_wb_v_o in cycle N+1.
REQ-008 late_wb_v_o SHALL be count != 0, and late_wb_pkt_o SHALL be the head entry's pkt.
REQ-009 A dequeue SHALL occur on late_wb_yumi_i & late_wb_v_o.
REQ-010 late_wb_yumi_i with late_wb_v_o=0 SHALL be ignored, and SHALL be flagged by a simulation assertion.
REQ-011 A simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-012 Pointers SHALL be log2(els_p) bits and wrap naturally; count SHALL be log2(els_p)+1 bits.
REQ-013 The head-age counter (width clog2(starve_p+1)) SHALL:
- clear to 0 on any dequeue, and on an enqueue into an empty buffer;
- otherwise increment, saturating at starve_p, while late_wb_v_o & ~late_wb_yumi_i;
- hold when the buffer is empty.
REQ-014 late_wb_force_o SHALL be late_wb_v_o & ((age >= starve_p) | (count == els_p)), combinational from registered state.
REQ-015 pending_irf_o[r] SHALL be the OR over valid entries of (irf & rd_addr==r).
REQ-016 pending_frf_o[r] SHALL be the OR over valid entries of (frf & rd_addr==r).
REQ-017 pending_irf_o[0] SHALL be constant 0.
REQ-018 A register with several queued writes SHALL stay pending until its last entry dequeues.
REQ-019 An enqueue with wb_irf_i=wb_frf_i=0 SHALL still occupy an entry (e.g. a fflags-only result) and SHALL set no pending bit.
REQ-020 Entries SHALL never be dropped or reordered; there is no flush input, because late writebacks are architecturally committed.

Reset
REQ-021 On reset_n_i low, asynchronously, the block SHALL clear pointers, count and age to 0; entry data need not be reset.
REQ-022 During and immediately after reset: late_wb_v_o=0, late_wb_force_o=0, wb_ready_and_o=1, pending_irf_o=0, pending_frf_o=0.
REQ-023 Reset asserted mid-operation SHALL discard all entries, with outputs at reset values within the same cycle.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Single pass: enqueue irf rd=5 at cycle 0 -> cycle 1: late_wb_v_o=1, pending_irf_o=0x20; yumi at cycle 1 -> cycle 2: v=0, pending=0.
- Fill: 4 enqueues without yumi (els_p=4) -> wb_ready_and_o=0 and late_wb_force_o=1 after the 4th; a 5th wb_v_i is not accepted; one yumi -> ready=1.
- Starvation: one entry held with yumi=0 -> force=0 for cycles 1..8 after enqueue, force=1 from the 9th cycle (age=8); yumi clears force next cycle.
- Wrap plus concurrency: 10 enqueues with concurrent yumis every cycle -> packets emerge in order, count stays <=1, no loss across pointer wrap.
- Pending corner cases: two frf rd=3 entries -> pending_frf_o[3] stays 1 after the first dequeue and clears after the second; irf rd=0 -> pending_irf_o stays 0.
- Async reset: reset_n_i asserted with 3 entries queued -> v=0, ready=1, pending=0 before the next clock edge.
